// File: rtl/snake_step_ctrl.sv
// Snake move-step controller: keeps the body as a ring in external RAM, checks the new head
// against the walls and the body, then commits the move and requests a new item when eaten.
module snake_step_ctrl #(
    parameter int unsigned MAX_SIZE = 100,
    parameter int unsigned XSIZE    = 48,
    parameter int unsigned YSIZE    = 64,
    parameter int unsigned DEF_SIZE = 3
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Step,
    input  logic [5:0]  i_Head_x,
    input  logic [5:0]  i_Head_y,
    input  logic [5:0]  i_Item_x,
    input  logic [5:0]  i_Item_y,
    output logic [6:0]  o_Ram_Addr,
    output logic        o_Ram_We,
    output logic [11:0] o_Ram_Wdata,
    input  logic [11:0] i_Ram_Rdata,
    output logic        o_Item_Req,
    input  logic        i_Item_Ack,
    output logic [6:0]  o_Size,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Eat,
    output logic        o_GameOver
);

    typedef enum logic [3:0] {
        StInit, StIdle, StWall, StScan, StWait, StWrite, StItem, StDone, StOver
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [6:0]  hptr_q, hptr_d;
    logic [6:0]  size_q, size_d;
    logic [11:0] head_q, head_d;
    logic        eat_q, eat_d;
    logic        rd_valid_q;

    logic [6:0]  n_reads;
    logic [6:0]  hptr_inc;
    logic [6:0]  rd_addr;
    logic        hit;
    logic        wall;

    assign n_reads  = eat_q ? size_q : size_q - 7'd1;
    assign hptr_inc = (hptr_q == 7'(MAX_SIZE - 1)) ? 7'd0 : hptr_q + 7'd1;
    // 7-bit wrap is harmless here: the true result always lies in 0..MAX_SIZE-1.
    assign rd_addr  = (hptr_q >= cnt_q) ? hptr_q - cnt_q : hptr_q + 7'(MAX_SIZE) - cnt_q;
    // Read data lands one cycle after its address, so compare against the previous read.
    assign hit      = rd_valid_q && (i_Ram_Rdata == head_q);
    assign wall     = (head_q[11:6] == 6'd0) || (head_q[5:0] == 6'd0) ||
                      (head_q[11:6] == 6'(XSIZE - 1)) || (head_q[5:0] == 6'(YSIZE - 1));

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q    <= StInit;
            cnt_q      <= 7'd0;
            hptr_q     <= 7'd0;
            size_q     <= 7'(DEF_SIZE);
            head_q     <= 12'd0;
            eat_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hptr_q     <= hptr_d;
            size_q     <= size_d;
            head_q     <= head_d;
            eat_q      <= eat_d;
            rd_valid_q <= (state_q == StScan);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hptr_d      = hptr_q;
        size_d      = size_q;
        head_d      = head_q;
        eat_d       = eat_q;
        o_Ram_Addr  = 7'd0;
        o_Ram_We    = 1'b0;
        o_Ram_Wdata = 12'd0;
        o_Item_Req  = 1'b0;
        o_Done      = 1'b0;
        o_Eat       = 1'b0;

        unique case (state_q)
            StInit: begin
                // Held in INIT by reset, so the write strobe must not leak out during reset.
                o_Ram_We    = ~i_Rst;
                o_Ram_Addr  = cnt_q;
                o_Ram_Wdata = {6'd24, 6'd30 + cnt_q[5:0]};
                if (cnt_q == 7'(DEF_SIZE - 1)) begin
                    cnt_d   = 7'd0;
                    hptr_d  = 7'(DEF_SIZE - 1);
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            StIdle: begin
                if (i_Step) begin
                    head_d  = {i_Head_x, i_Head_y};
                    eat_d   = (i_Head_x == i_Item_x) && (i_Head_y == i_Item_y);
                    state_d = StWall;
                end
            end
            StWall: begin
                cnt_d   = 7'd0;
                state_d = wall ? StOver : StScan;
            end
            StScan: begin
                o_Ram_Addr = rd_addr;
                if (hit) begin
                    state_d = StOver;
                end else if (cnt_q == n_reads - 7'd1) begin
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            StWait: begin
                state_d = hit ? StOver : StWrite;
            end
            StWrite: begin
                hptr_d      = hptr_inc;
                o_Ram_We    = 1'b1;
                o_Ram_Addr  = hptr_inc;
                o_Ram_Wdata = head_q;
                if (eat_q && (size_q < 7'(MAX_SIZE))) begin
                    size_d = size_q + 7'd1;
                end
                state_d = eat_q ? StItem : StDone;
            end
            StItem: begin
                o_Item_Req = 1'b1;
                if (i_Item_Ack) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                o_Done  = 1'b1;
                o_Eat   = eat_q;
                state_d = StIdle;
            end
            StOver: begin
                state_d = StOver;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    assign o_Size     = size_q;
    assign o_Busy     = !((state_q == StIdle) || (state_q == StOver));
    assign o_GameOver = (state_q == StOver);

endmodule
